regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file with registered reads, write-to-read bypass
//  and a per-register busy scoreboard. Sits in the decode/issue stage; WB drives write ports.
//  x0 is hardwired to zero. Next generation of the core's 2R1W register file.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_bypass_mux.sv | 33 +++
 rtl/regfile_mp.sv | 137 +++++++++++++
 tb/tb_regfile_mp.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types, constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NUM_REGS = 32;
  localparam int unsigned RF_ADDR_W   = $clog2(RF_NUM_REGS);
  localparam int unsigned ZERO_REG    = 0;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_DATA_W-1:0] word_t;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_par(input word_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port source select: x0, same-cycle write data (highest port wins) or array data.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NR_WR  = 1
) (
  input  logic [ADDR_W-1:0]       raddr,
  input  logic [DATA_W-1:0]       arr_data,
  input  logic [NR_WR-1:0]        we,
  input  logic [NR_WR*ADDR_W-1:0] waddr,
  input  logic [NR_WR*DATA_W-1:0] wdata,
  output logic [DATA_W-1:0]       data_c,
  output logic                    hit_c
);

  always_comb begin
    data_c = arr_data;
    hit_c  = 1'b0;
    for (int unsigned k = 0; k < NR_WR; k++) begin
      if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == raddr)) begin
        data_c = wdata[k*DATA_W +: DATA_W];
        hit_c  = 1'b1;
      end
    end
    if (raddr == ADDR_W'(ZERO_REG)) begin
      data_c = '0;
      hit_c  = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, write bypass and busy scoreboard.
// Optional per-entry parity protection is enabled by defining REGFILE_PARITY_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned NR_RD    = 2,
  parameter int unsigned NR_WR    = 1,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NR_WR-1:0]        we_i,
  input  logic [NR_WR*ADDR_W-1:0] waddr_i,
  input  logic [NR_WR*DATA_W-1:0] wdata_i,
  input  logic                    par_inj_i,
  input  logic [NR_RD-1:0]        re_i,
  input  logic [NR_RD*ADDR_W-1:0] raddr_i,
  output logic [NR_RD*DATA_W-1:0] rdata_o,
  output logic [NR_RD-1:0]        rvalid_o,
  output logic [NR_RD-1:0]        rbusy_o,
  output logic [NR_RD-1:0]        par_err_o,
  input  logic                    sb_set_i,
  input  logic [ADDR_W-1:0]       sb_addr_i,
  output logic                    x0_wr_o
);

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] wr_mask_c;
  logic [NUM_REGS-1:0] busy_clr_c;
  logic [NUM_REGS-1:0] busy_nxt_c;
  logic                x0_hit_c;
  logic [DATA_W-1:0]   arr_rd_c  [NR_RD];
  logic [DATA_W-1:0]   rd_data_c [NR_RD];
  logic [NR_RD-1:0]    rd_hit_c;

  // Decode enabled writes into a per-register clear mask and an x0 hit.
  always_comb begin
    wr_mask_c = '0;
    x0_hit_c  = 1'b0;
    for (int unsigned k = 0; k < NR_WR; k++) begin
      if (we_i[k]) begin
        if (waddr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(ZERO_REG)) x0_hit_c = 1'b1;
        else wr_mask_c[waddr_i[k*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
  end

  assign busy_clr_c = busy_q & ~wr_mask_c;

  // Set is applied after the clear so an issue on the same rd keeps it busy.
  always_comb begin
    busy_nxt_c = busy_clr_c;
    if (sb_set_i) busy_nxt_c[sb_addr_i] = 1'b1;
    busy_nxt_c[ZERO_REG] = 1'b0;
  end

  for (genvar j = 0; j < NR_RD; j++) begin : g_rd
    assign arr_rd_c[j] = mem_q[raddr_i[j*ADDR_W +: ADDR_W]];

    regfile_bypass_mux #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .NR_WR (NR_WR)
    ) u_mux (
      .raddr   (raddr_i[j*ADDR_W +: ADDR_W]),
      .arr_data(arr_rd_c[j]),
      .we      (we_i),
      .waddr   (waddr_i),
      .wdata   (wdata_i),
      .data_c  (rd_data_c[j]),
      .hit_c   (rd_hit_c[j])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      busy_q   <= '0;
      rdata_o  <= '0;
      rvalid_o <= '0;
      rbusy_o  <= '0;
      x0_wr_o  <= 1'b0;
    end else begin
      // Ascending port order lets the highest index win on collisions.
      for (int unsigned k = 0; k < NR_WR; k++) begin
        if (we_i[k] && (waddr_i[k*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG)))
          mem_q[waddr_i[k*ADDR_W +: ADDR_W]] <= wdata_i[k*DATA_W +: DATA_W];
      end
      busy_q   <= busy_nxt_c;
      x0_wr_o  <= x0_hit_c;
      rvalid_o <= re_i;
      for (int unsigned j = 0; j < NR_RD; j++) begin
        if (re_i[j]) begin
          rdata_o[j*DATA_W +: DATA_W] <= rd_data_c[j];
          rbusy_o[j] <= busy_clr_c[raddr_i[j*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

`ifdef REGFILE_PARITY_EN
  logic [NUM_REGS-1:0] par_q;
  logic [NR_RD-1:0]    par_bad_c;

  // Only array-sourced, non-x0 reads can flag a parity mismatch.
  for (genvar j = 0; j < NR_RD; j++) begin : g_par
    assign par_bad_c[j] = !rd_hit_c[j]
                          && (raddr_i[j*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))
                          && (even_par(word_t'(arr_rd_c[j]))
                              != par_q[raddr_i[j*ADDR_W +: ADDR_W]]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      par_q     <= '0;
      par_err_o <= '0;
    end else begin
      for (int unsigned k = 0; k < NR_WR; k++) begin
        if (we_i[k] && (waddr_i[k*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG)))
          par_q[waddr_i[k*ADDR_W +: ADDR_W]] <=
            even_par(word_t'(wdata_i[k*DATA_W +: DATA_W])) ^ par_inj_i;
      end
      for (int unsigned j = 0; j < NR_RD; j++) begin
        if (re_i[j]) par_err_o[j] <= par_bad_c[j];
      end
    end
  end
`else
  logic unused_par;
  assign unused_par = par_inj_i ^ (^rd_hit_c);
  assign par_err_o  = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven check of regfile_mp configured as 2R2W.
module tb_regfile_mp;

`ifdef REGFILE_PARITY_EN
  localparam logic P = 1'b1;
`else
  localparam logic P = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        par_inj;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rvalid;
  logic [1:0]  rbusy;
  logic [1:0]  par_err;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        x0_wr;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NR_RD(2), .NR_WR(2)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .par_inj_i(par_inj),
    .re_i     (re),
    .raddr_i  (raddr),
    .rdata_o  (rdata),
    .rvalid_o (rvalid),
    .rbusy_o  (rbusy),
    .par_err_o(par_err),
    .sb_set_i (sb_set),
    .sb_addr_i(sb_addr),
    .x0_wr_o  (x0_wr)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        inj;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic        sb;
    logic [4:0]  sba;
    logic [1:0]  rv;
    logic [31:0] d0, d1;
    logic [1:0]  rb;
    logic        x0;
    logic [1:0]  pe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    logic [1:0] we_, logic [4:0] wa0, logic [31:0] wd0, logic [4:0] wa1, logic [31:0] wd1,
    logic inj, logic [1:0] re_, logic [4:0] ra0, logic [4:0] ra1, logic sb, logic [4:0] sba,
    logic [1:0] rv, logic [31:0] d0, logic [31:0] d1, logic [1:0] rb, logic x0, logic [1:0] pe);
    vec_t r;
    r.we = we_; r.wa0 = wa0; r.wd0 = wd0; r.wa1 = wa1; r.wd1 = wd1; r.inj = inj;
    r.re = re_; r.ra0 = ra0; r.ra1 = ra1; r.sb = sb; r.sba = sba;
    r.rv = rv; r.d0 = d0; r.d1 = d1; r.rb = rb; r.x0 = x0; r.pe = pe;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input vec_t t);
    we = t.we; waddr = {t.wa1, t.wa0}; wdata = {t.wd1, t.wd0}; par_inj = t.inj;
    re = t.re; raddr = {t.ra1, t.ra0}; sb_set = t.sb; sb_addr = t.sba;
  endtask

  task automatic step_chk(input string tag, input vec_t t);
    drive(t);
    @(posedge clk); #1;
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(t.rv));
    chk({tag, ".rdata0"}, rdata[31:0], t.d0);
    chk({tag, ".rdata1"}, rdata[63:32], t.d1);
    chk({tag, ".rbusy"}, 32'(rbusy), 32'(t.rb));
    chk({tag, ".x0_wr"}, 32'(x0_wr), 32'(t.x0));
    chk({tag, ".par_err"}, 32'(par_err), 32'(t.pe));
  endtask

  vec_t idle;

  initial begin
    idle = v(2'b00, 0, 0, 0, 0, 1'b0, 2'b00, 0, 0, 1'b0, 0, 2'b00, 0, 0, 2'b00, 1'b0, 2'b00);
    drive(idle);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rdata", rdata[31:0] | rdata[63:32], 32'h0);
    chk("reset.flags", 32'({rvalid, rbusy, par_err, x0_wr}), 32'h0);
    rst_n = 1'b1;

    // Fresh registers read zero and not busy on both ports.
    for (int a = 1; a < 32; a++) begin
      vec_t t;
      t = idle;
      t.re = 2'b11; t.ra0 = 5'(a); t.ra1 = 5'(32 - a);
      t.rv = 2'b11;
      step_chk($sformatf("init_x%0d", a), t);
    end
    step_chk("idle_after_init", idle);

    vecs.push_back(v(2'b01, 5, 32'hDEADBEEF, 0, 0, 1'b0, 2'b01, 5, 0, 1'b0, 0,
                     2'b01, 32'hDEADBEEF, 0, 2'b00, 1'b0, 2'b00));
    vecs.push_back(v(2'b00, 0, 0, 0, 0, 1'b0, 2'b11, 5, 5, 1'b0, 0,
                     2'b11, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0, 2'b00));
    vecs.push_back(v(2'b11, 7, 32'h1, 7, 32'h2, 1'b0, 2'b01, 7, 0, 1'b0, 0,
                     2'b01, 32'h2, 32'hDEADBEEF, 2'b00, 1'b0, 2'b00));
    vecs.push_back(v(2'b00, 0, 0, 0, 0, 1'b0, 2'b10, 0, 7, 1'b0, 0,
                     2'b10, 32'h2, 32'h2, 2'b00, 1'b0, 2'b00));
    vecs.push_back(v(2'b01, 0, 32'hFFFFFFFF, 0, 0, 1'b0, 2'b01, 0, 0, 1'b0, 0,
                     2'b01, 32'h0, 32'h2, 2'b00, 1'b1, 2'b00));
    vecs.push_back(v(2'b00, 0, 0, 0, 0, 1'b0, 2'b01, 0, 0, 1'b0, 0,
                     2'b01, 32'h0, 32'h2, 2'b00, 1'b0, 2'b00));
    vecs.push_back(v(2'b00, 0, 0, 0, 0, 1'b0, 2'b01, 9, 0, 1'b1, 9,
                     2'b01, 32'h0, 32'h2, 2'b00, 1'b0, 2'b00));
    vecs.push_back(v(2'b00, 0, 0, 0, 0, 1'b0, 2'b01, 9, 0, 1'b0, 0,
                     2'b01, 32'h0, 32'h2, 2'b01, 1'b0, 2'b00));
    vecs.push_back(v(2'b01, 9, 32'h99, 0, 0, 1'b0, 2'b11, 9, 9, 1'b1, 9,
                     2'b11, 32'h99, 32'h99, 2'b00, 1'b0, 2'b00));
    vecs.push_back(v(2'b00, 0, 0, 0, 0, 1'b0, 2'b01, 9, 0, 1'b0, 0,
                     2'b01, 32'h99, 32'h99, 2'b01, 1'b0, 2'b00));
    vecs.push_back(v(2'b10, 0, 0, 9, 32'hAA, 1'b0, 2'b10, 0, 9, 1'b0, 0,
                     2'b10, 32'h99, 32'hAA, 2'b01, 1'b0, 2'b00));
    vecs.push_back(v(2'b00, 0, 0, 0, 0, 1'b0, 2'b11, 9, 9, 1'b0, 0,
                     2'b11, 32'hAA, 32'hAA, 2'b00, 1'b0, 2'b00));
    vecs.push_back(v(2'b01, 3, 32'h7, 0, 0, 1'b1, 2'b00, 0, 0, 1'b0, 0,
                     2'b00, 32'hAA, 32'hAA, 2'b00, 1'b0, 2'b00));
    vecs.push_back(v(2'b00, 0, 0, 0, 0, 1'b0, 2'b01, 3, 0, 1'b0, 0,
                     2'b01, 32'h7, 32'hAA, 2'b00, 1'b0, {1'b0, P}));
    vecs.push_back(v(2'b01, 3, 32'h7, 0, 0, 1'b0, 2'b10, 0, 3, 1'b0, 0,
                     2'b10, 32'h7, 32'h7, 2'b00, 1'b0, {1'b0, P}));
    vecs.push_back(v(2'b00, 0, 0, 0, 0, 1'b0, 2'b01, 3, 0, 1'b0, 0,
                     2'b01, 32'h7, 32'h7, 2'b00, 1'b0, 2'b00));
    vecs.push_back(v(2'b00, 0, 0, 0, 0, 1'b0, 2'b00, 0, 0, 1'b1, 0,
                     2'b00, 32'h7, 32'h7, 2'b00, 1'b0, 2'b00));
    vecs.push_back(v(2'b00, 0, 0, 0, 0, 1'b0, 2'b01, 0, 0, 1'b0, 0,
                     2'b01, 32'h0, 32'h7, 2'b00, 1'b0, 2'b00));

    foreach (vecs[i]) step_chk($sformatf("vec%0d", i), vecs[i]);

    // Reset in the same cycle as a write, an x0 write, a busy set and reads.
    begin
      vec_t t;
      t = v(2'b11, 12, 32'h55, 0, 32'h1, 1'b0, 2'b11, 5, 5, 1'b1, 12,
            2'b00, 0, 0, 2'b00, 1'b0, 2'b00);
      rst_n = 1'b0;
      step_chk("midrst", t);
      rst_n = 1'b1;
      t = v(2'b00, 0, 0, 0, 0, 1'b0, 2'b11, 12, 5, 1'b0, 0,
            2'b11, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      step_chk("post_rst", t);
      t = v(2'b00, 0, 0, 0, 0, 1'b0, 2'b11, 7, 9, 1'b0, 0,
            2'b11, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
      step_chk("post_rst2", t);
    end

    drive(idle);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
